// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
// Result flags are packed as {gt, eq, lt}.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned RES_W  = 3;
    localparam int unsigned RES_GT = 2;
    localparam int unsigned RES_EQ = 1;
    localparam int unsigned RES_LT = 0;

endpackage

// File: rtl/serial_magnitude_comparator_cell.sv
// One combinational comparison cell: folds a single bit pair into the running
// equal/greater flags; the first differing bit decides, later bits are ignored.
module comparator_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic invert,
    input  logic eq_in,
    input  logic gt_in,
    output logic eq_out,
    output logic gt_out
);

    always_comb begin
        eq_out = eq_in;
        gt_out = gt_in;
        if (eq_in && (a_bit != b_bit)) begin
            eq_out = 1'b0;
            // A set sign bit means the smaller value in two's complement.
            gt_out = invert ? b_bit : a_bit;
        end
    end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator with start/busy/done handshake,
// optional two's-complement mode and optional early exit.
module serial_magnitude_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SIGNED     = 0,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int unsigned IW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               eq_mid_q, eq_mid_d;
    logic               gt_mid_q, gt_mid_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic               busy_q, done_q;

    logic cell_eq, cell_gt, cell_invert, last_bit;

    assign cell_invert = (SIGNED != 0) && (idx_q == IW'(WIDTH - 1));
    assign last_bit    = (idx_q == '0);

    comparator_cell u_cell (
        .a_bit  (a_q[idx_q]),
        .b_bit  (b_q[idx_q]),
        .invert (cell_invert),
        .eq_in  (eq_mid_q),
        .gt_in  (gt_mid_q),
        .eq_out (cell_eq),
        .gt_out (cell_gt)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        eq_mid_d = eq_mid_q;
        gt_mid_d = gt_mid_q;
        res_d    = res_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SCAN;
                    a_d      = a;
                    b_d      = b;
                    idx_d    = IW'(WIDTH - 1);
                    eq_mid_d = 1'b1;
                    gt_mid_d = 1'b0;
                    res_d    = '0;
                end
            end
            SCAN: begin
                eq_mid_d = cell_eq;
                gt_mid_d = cell_gt;
                if (last_bit || ((EARLY_EXIT != 0) && !cell_eq)) begin
                    state_d        = DONE;
                    res_d[RES_GT]  = cell_gt;
                    res_d[RES_EQ]  = cell_eq;
                    res_d[RES_LT]  = ~cell_gt & ~cell_eq;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            eq_mid_q <= 1'b1;
            gt_mid_q <= 1'b0;
            res_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            eq_mid_q <= eq_mid_d;
            gt_mid_q <= gt_mid_d;
            res_q    <= res_d;
            busy_q   <= (state_d == SCAN);
            done_q   <= (state_d == DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = res_q[RES_GT];
    assign eq   = res_q[RES_EQ];
    assign lt   = res_q[RES_LT];

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Parametrised, bit-serial magnitude comparator that scans two latched operands MSB-first, left to right, one bit per clock. It replaces the fixed combinational chain of comparison cells terminated by the final cell. Generalisations over that chain:
- configurable operand width
- optional two's-complement mode
- optional early exit on the first differing bit
- start/busy/done handshake

It sits between the operand registers and the result display/decision logic of the comparison datapath.

## Interface

Parameters:
- WIDTH, 8: operand width in bits; legal range 2..32.
- SIGNED, 0: 1 = operands are two's complement; 0 = unsigned.
- EARLY_EXIT, 1: 1 = finish on the first differing bit; 0 = always scan all WIDTH bits.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a comparison; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse; result is valid.
- gt  output  1  A > B.
- eq  output  1  A == B.
- lt  output  1  A < B.

## Operation

- FSM states: IDLE, SCAN, DONE.
  - IDLE -> SCAN on start=1.
  - SCAN -> DONE on the last bit, or on a difference when EARLY_EXIT=1.
  - DONE -> IDLE unconditionally.
- Accepting edge (IDLE with start=1):
  - latch a and b into internal registers;
  - set idx = WIDTH-1;
  - set running flags eq_mid=1, gt_mid=0.
- Each SCAN edge evaluates bit idx through the cell:
  - if eq_mid=1 and a[idx] != b[idx]: eq_mid <= 0 and gt_mid <= a[idx].
  - If SIGNED=1 and idx=WIDTH-1, the sign bit is inverted, so gt_mid <= b[idx].
  - Once eq_mid=0, later bits never change gt_mid or eq_mid.
- Leaving SCAN: on the edge that evaluates idx=0, or the edge that clears eq_mid when EARLY_EXIT=1, go to DONE. On that same edge register:
  - gt = gt_mid_next
  - lt = ~gt_mid_next & ~eq_mid_next
  - eq = eq_mid_next
- Otherwise idx decrements by 1 per SCAN edge. idx is a $clog2(WIDTH)-bit down-counter and never wraps below 0.
- Output invariant: exactly one of gt/eq/lt is high whenever any of them is non-zero.
- Result hold: gt/eq/lt hold their last result through DONE and IDLE. They are cleared to 0 on the next accepting edge.
- start while in SCAN or DONE is ignored. No queueing.
- Inputs a and b may change freely after the accepting edge without affecting the result.

## Timing

- Reset (asynchronous, immediate): state=IDLE, busy=0, done=0, gt=0, eq=0, lt=0, idx=0, eq_mid=1, gt_mid=0.
- Reset asserted mid-SCAN aborts the comparison. No done pulse is produced.
- Accepting edge is edge 0. busy is high from after edge 0 until the edge that enters DONE.
- Latency with EARLY_EXIT=0: always WIDTH SCAN edges. done is high during the cycle after edge WIDTH.
- Latency with EARLY_EXIT=1: first difference at bit k gives done after edge WIDTH-k. Equal operands give done after edge WIDTH.
- done is high for exactly one cycle, in DONE. busy=0 in DONE.
- The earliest next accepting edge is the edge after DONE (back in IDLE).
- Throughput: one comparison per (latency + 2) cycles.
- busy, done and gt/eq/lt are all registered outputs. There is no combinational path from any input to any output.

## Structure

- Package serial_cmp_pkg holds:
  - state enum IDLE=2'd0, SCAN=2'd1, DONE=2'd2;
  - localparams for the result-flag positions.
- Sub-module comparator_cell is purely combinational. It maps (a_bit, b_bit, invert, eq_in, gt_in) to (eq_out, gt_out) and is instantiated once.
- The top module holds the FSM, the operand registers, the idx counter and the output registers.

## Test plan

All scenarios use WIDTH=8.
- Equal operands: a=8'hA5, b=8'hA5, EARLY_EXIT=1 -> eq=1, gt=lt=0, done after edge 8, busy high for 8 cycles.
- MSB difference, unsigned: a=8'h80, b=8'h7F -> gt=1.
  - EARLY_EXIT=1: done after edge 1.
  - EARLY_EXIT=0: done after edge 8, same result.
- Same operands, SIGNED=1: a=8'h80, b=8'h7F -> lt=1 (-128 < 127), done after edge 1.
- LSB-only difference: a=8'h00, b=8'h01 -> lt=1, done after edge 8 in both modes.
- Start while busy: pulse start with a=8'hFF during SCAN of a=8'h10, b=8'h20 -> request ignored, result lt=1, exactly one done pulse.
- Reset mid-scan: assert rst at edge 3 of an 8-bit scan -> all outputs 0 immediately, no done pulse. A new start after reset release completes normally.
